// File: rtl/seg_display_ctrl.sv
// Four-digit multiplexed seven-segment driver: a sequential double-dabble turns the
// 9-bit ALU result into BCD, and a scan counter shows units/tens/hundreds/tag letter.
module seg_display_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [8:0] Out_with_carry,
  input  logic [3:0] Letters,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       conv_busy
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q;
  logic [8:0]  last_val_q;
  logic [20:0] shift_q;
  logic [20:0] adj_d;
  logic [20:0] shift_d;
  logic [3:0]  iter_q;
  logic [3:0]  hund_q;
  logic [3:0]  tens_q;
  logic [3:0]  units_q;
  logic        conv_busy_q;

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q;
  logic [3:0]    an_d;
  logic [6:0]    seg_q;
  logic [6:0]    seg_d;

  function automatic logic [3:0] bcd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [6:0] seg_letter(input logic [3:0] l);
    case (l)
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      default: return SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: correct each BCD nibble, then shift the whole register.
  always_comb begin
    adj_d   = {bcd_adj(shift_q[20:17]), bcd_adj(shift_q[16:13]),
               bcd_adj(shift_q[12:9]), shift_q[8:0]};
    shift_d = adj_d << 1;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_val_q  <= 9'd0;
      shift_q     <= 21'd0;
      iter_q      <= 4'd0;
      hund_q      <= 4'd0;
      tens_q      <= 4'd0;
      units_q     <= 4'd0;
      conv_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Out_with_carry != last_val_q) begin
            shift_q     <= {12'd0, Out_with_carry};
            last_val_q  <= Out_with_carry;
            iter_q      <= 4'd0;
            state_q     <= CONV;
            conv_busy_q <= 1'b1;
          end
        end
        CONV: begin
          shift_q <= shift_d;
          iter_q  <= iter_q + 4'd1;
          if (iter_q == 4'd8) begin
            hund_q      <= shift_d[20:17];
            tens_q      <= shift_d[16:13];
            units_q     <= shift_d[12:9];
            state_q     <= IDLE;
            conv_busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Leading zeros are blanked; the letter tag bypasses the converter entirely.
  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = SEG_BLANK;
    case (idx_q)
      2'd0: seg_d = seg_digit(units_q);
      2'd1: seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? SEG_BLANK : seg_digit(tens_q);
      2'd2: seg_d = (hund_q == 4'd0) ? SEG_BLANK : seg_digit(hund_q);
      default: seg_d = seg_letter(Letters);
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      if (presc_q == PS_LAST) begin
        presc_q <= '0;
        idx_q   <= idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;
  assign conv_busy = conv_busy_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: expected digit frames are queued by the
// stimulus and checked by monitors as each new digit appears on the display.
module tb_seg_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S5 = 7'b0010010, S7 = 7'b1111000,
                         SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110,
                         SX = 7'b1111111;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] Out_with_carry = 9'd0;
  logic [3:0] Letters = 4'h0;
  logic [3:0] an, an2;
  logic [6:0] seg, seg2;
  logic       dp, dp2, conv_busy, conv_busy2;

  int checks = 0;
  int errors = 0;
  logic [10:0] q[$];
  logic [3:0]  q2[$];
  logic        busy_seen = 1'b0;

  seg_display_ctrl #(.REFRESH_DIV(4)) dut (
    .Clk(Clk), .reset(reset), .Out_with_carry(Out_with_carry), .Letters(Letters),
    .an(an), .seg(seg), .dp(dp), .conv_busy(conv_busy));

  seg_display_ctrl #(.REFRESH_DIV(2)) dut2 (
    .Clk(Clk), .reset(reset), .Out_with_carry(Out_with_carry), .Letters(Letters),
    .an(an2), .seg(seg2), .dp(dp2), .conv_busy(conv_busy2));

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Main display monitor: each new digit pops one expectation; a popped digit
  // must then be held for exactly REFRESH_DIV cycles.
  logic [3:0] prev_an = 4'hF;
  int run = 0;
  logic lenflag = 1'b0;
  always @(negedge Clk) begin
    logic [10:0] e;
    if (an != prev_an) begin
      if (lenflag && an != 4'hF) chk("hold_len", run, 4);
      lenflag = 1'b0;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("digit", {an, seg}, e);
        lenflag = 1'b1;
      end
      run = 1;
    end else begin
      run++;
    end
    if (an == 4'hF) lenflag = 1'b0;
    prev_an = an;
  end

  // Fast-scan monitor: one expected an value per cycle while queued.
  always @(negedge Clk) begin
    logic [3:0] e2;
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      chk("scan_an", an2, e2);
    end
  end

  always @(negedge Clk) if (conv_busy) busy_seen = 1'b1;

  task automatic wait_an(input logic [3:0] v);
    int t = 0;
    do begin
      @(negedge Clk);
      t++;
    end while (an != v && t < 200);
    if (an != v) begin
      errors++;
      $display("FAIL wait_an actual=%b required=%b", an, v);
    end
  endtask

  task automatic frame(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h,
                       input logic [6:0] l);
    int w = 0;
    wait_an(4'b1011);
    wait_an(4'b0111);
    @(negedge Clk);
    q.push_back({4'b1110, u});
    q.push_back({4'b1101, t});
    q.push_back({4'b1011, h});
    q.push_back({4'b0111, l});
    while (q.size() != 0 && w < 200) begin
      @(negedge Clk);
      w++;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL frame_timeout actual=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic conv_run(input logic [8:0] v, input string nm);
    int cnt = 0;
    Out_with_carry = v;
    @(negedge Clk);
    while (conv_busy && cnt < 50) begin
      cnt++;
      @(negedge Clk);
    end
    chk(nm, cnt, 9);
  endtask

  initial begin
    int cnt;
    int w;
    logic [3:0] pat[4];
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

    repeat (3) @(negedge Clk);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, SX);
    chk("rst_dp", dp, 1'b1);
    chk("rst_busy", conv_busy, 1'b0);

    // Release; fast scanner expected to walk the one-cold pattern, 2 cycles each.
    @(negedge Clk);
    #1 reset = 1'b0;
    for (int k = 1; k <= 20; k++) q2.push_back(pat[((k - 1) / 2) % 4]);
    @(negedge Clk);
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, S0);
    w = 0;
    while (q2.size() != 0 && w < 60) begin
      @(negedge Clk);
      w++;
    end
    chk("scan_done", q2.size(), 0);
    chk("idle_busy", busy_seen, 1'b0);

    Letters = 4'hA;
    conv_run(9'd511, "busy_511");
    frame(S1, S1, S5, SA);

    Letters = 4'hB;
    conv_run(9'd7, "busy_7");
    frame(S7, SX, SX, SB);
    conv_run(9'd305, "busy_305");
    frame(S5, S0, S3, SB);

    // Input change absorbed mid-conversion, then picked up on the next IDLE cycle.
    cnt = 0;
    Out_with_carry = 9'd100;
    @(negedge Clk);
    while (conv_busy && cnt < 50) begin
      cnt++;
      if (cnt == 3) Out_with_carry = 9'd200;
      @(negedge Clk);
    end
    chk("busy_100", cnt, 9);
    chk("digits_100", {dut.hund_q, dut.tens_q, dut.units_q}, 12'h100);
    cnt = 0;
    @(negedge Clk);
    while (conv_busy && cnt < 50) begin
      cnt++;
      @(negedge Clk);
    end
    chk("busy_200", cnt, 9);
    frame(S0, S0, S2, SB);

    busy_seen = 1'b0;
    Letters = 4'hC;
    frame(S0, S0, S2, SC);
    Letters = 4'h0;
    frame(S0, S0, S2, SX);
    Letters = 4'h5;
    frame(S0, S0, S2, SX);
    chk("letters_busy", busy_seen, 1'b0);

    Letters = 4'hA;
    conv_run(9'd511, "busy_511b");
    frame(S1, S1, S5, SA);

    // Asynchronous reset while a new conversion is in flight.
    Out_with_carry = 9'd300;
    @(negedge Clk);
    chk("busy_pre_rst", conv_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_an", an, 4'b1111);
    chk("async_seg", seg, SX);
    chk("async_busy", conv_busy, 1'b0);
    Out_with_carry = 9'd0;
    @(negedge Clk);
    @(negedge Clk);
    #1 reset = 1'b0;
    busy_seen = 1'b0;
    @(negedge Clk);
    chk("rel_an", an, 4'b1110);
    chk("rel_seg", seg, S0);
    frame(S0, SX, SX, SA);
    chk("rel_busy", busy_seen, 1'b0);
    chk("dp_const", dp, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
